// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared FSM state, queue entry type and PC step for the fetch queue
package ifetch_queue_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} ifq_state_e;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ifq_entry_t;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/ifetch_queue_ifq_fifo.sv
// ifq_fifo: DEPTH-entry instruction/PC FIFO, synchronous write, asynchronous read, flush clears it
module ifq_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   wr_inst,
  input  logic [31:0]   wr_pc,
  output logic [31:0]   rd_inst,
  output logic [31:0]   rd_pc,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  ifq_entry_t    mem_q [DEPTH];
  ifq_entry_t    head;
  // pointers wrap naturally because DEPTH is a power of two; flush wins over push/pop
  always_comb begin
    wr_ptr_d = flush ? '0 : push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage needs no reset: an empty queue masks its read data to zero
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wr_ptr_q] <= '{inst: wr_inst, pc: wr_pc};
  end
  assign head    = mem_q[rd_ptr_q];
  assign empty   = count_q == '0;
  assign count   = count_q;
  assign rd_inst = empty ? '0 : head.inst;
  assign rd_pc   = empty ? '0 : head.pc;
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch FSM feeding a FIFO; IFQ_PERF_EN adds stall/flush counters
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        Icache_req,
  output logic [31:0] Icache_addr,
  input  logic        Icache_ready,
  input  logic        Icache_valid,
  input  logic [31:0] Icache_data,
  output logic [31:0] Ifq_inst,
  output logic [31:0] Ifq_pc,
  output logic        Ifq_empty,
  input  logic        Dispatch_ren,
  input  logic        Jmp_branch_valid,
  input  logic [31:0] Jmp_branch_address
`ifdef IFQ_PERF_EN
  ,
  output logic [31:0] Ifq_stall_cnt,
  output logic [15:0] Ifq_flush_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  ifq_state_e    state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count;
  logic          can_req, push, pop;
  // a stale response after reset lands in IDLE and is ignored there
  always_comb begin
    can_req    = count < CW'(DEPTH);
    Icache_req = reset && state_q == IDLE && can_req && !Jmp_branch_valid;
    push       = state_q == WAIT && Icache_valid && !Jmp_branch_valid;
    pop        = Dispatch_ren && !Ifq_empty && !Jmp_branch_valid;
    state_d    = Jmp_branch_valid ? (state_q == WAIT ? DISCARD : IDLE)
               : state_q == IDLE  ? (Icache_req && Icache_ready ? WAIT : IDLE)
               : Icache_valid     ? IDLE : state_q;
    pc_d       = Jmp_branch_valid ? Jmp_branch_address : push ? pc_q + PC_INC : pc_q;
  end
  // FSM state and fetch PC registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  assign Icache_addr = {pc_q[31:2], 2'b00};
  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (Jmp_branch_valid),
    .wr_inst (Icache_data),
    .wr_pc   (pc_q),
    .rd_inst (Ifq_inst),
    .rd_pc   (Ifq_pc),
    .count   (count),
    .empty   (Ifq_empty)
  );
`ifdef IFQ_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;
  // saturating event counters
  always_comb begin
    stall_d = (state_q == IDLE && !can_req && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
    flush_d = (Jmp_branch_valid && !(&flush_q)) ? flush_q + 16'd1 : flush_q;
  end
  // counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign Ifq_stall_cnt = stall_q;
  assign Ifq_flush_cnt = flush_q;
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed self-checking bench for ifetch_queue
module tb_ifetch_queue;
  logic        clock = 0;
  logic        reset = 0;
  logic        Icache_req;
  logic [31:0] Icache_addr;
  logic        Icache_ready = 0;
  logic        Icache_valid = 0;
  logic [31:0] Icache_data = '0;
  logic [31:0] Ifq_inst;
  logic [31:0] Ifq_pc;
  logic        Ifq_empty;
  logic        Dispatch_ren = 0;
  logic        Jmp_branch_valid = 0;
  logic [31:0] Jmp_branch_address = '0;
`ifdef IFQ_PERF_EN
  logic [31:0] Ifq_stall_cnt;
  logic [15:0] Ifq_flush_cnt;
`endif
  int checks = 0;
  int failures = 0;

  ifetch_queue dut (
    .clock              (clock),
    .reset              (reset),
    .Icache_req         (Icache_req),
    .Icache_addr        (Icache_addr),
    .Icache_ready       (Icache_ready),
    .Icache_valid       (Icache_valid),
    .Icache_data        (Icache_data),
    .Ifq_inst           (Ifq_inst),
    .Ifq_pc             (Ifq_pc),
    .Ifq_empty          (Ifq_empty),
    .Dispatch_ren       (Dispatch_ren),
    .Jmp_branch_valid   (Jmp_branch_valid),
    .Jmp_branch_address (Jmp_branch_address)
`ifdef IFQ_PERF_EN
    ,
    .Ifq_stall_cnt      (Ifq_stall_cnt),
    .Ifq_flush_cnt      (Ifq_flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // request accepted on the next edge, response returned the edge after
  task automatic fetch(input logic [31:0] d);
    tick;
    chk("wait_req", 32'(Icache_req), 0);
    Icache_valid = 1;
    Icache_data  = d;
    tick;
    Icache_valid = 0;
  endtask

  initial begin
    #1;
    chk("rst_req", 32'(Icache_req), 0);
    chk("rst_empty", 32'(Ifq_empty), 1);
    chk("rst_inst", Ifq_inst, 0);
    chk("rst_pc", Ifq_pc, 0);
    chk("rst_addr", Icache_addr, 0);
    tick;
    tick;
    reset = 1;
    Icache_ready = 1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_req", 32'(Icache_req), 1);
      chk("seq_addr", Icache_addr, 32'(4 * i));
      fetch(32'hA000_0000 + 32'(i));
      chk("seq_empty", 32'(Ifq_empty), 0);
      chk("seq_head_pc", Ifq_pc, 0);
    end
    chk("full_req", 32'(Icache_req), 0);
    chk("full_inst", Ifq_inst, 32'hA000_0000);
    tick;
    chk("full_hold_req", 32'(Icache_req), 0);
    chk("full_hold_empty", 32'(Ifq_empty), 0);
    Dispatch_ren = 1;
    tick;
    Dispatch_ren = 0;
    chk("pop_req", 32'(Icache_req), 1);
    chk("pop_addr", Icache_addr, 32'h10);
    chk("pop_head_inst", Ifq_inst, 32'hA000_0001);
    chk("pop_head_pc", Ifq_pc, 32'h4);
    tick;
    Jmp_branch_valid = 1;
    Jmp_branch_address = 32'h100;
    tick;
    Jmp_branch_valid = 0;
    chk("redir_empty", 32'(Ifq_empty), 1);
    chk("redir_req", 32'(Icache_req), 0);
    chk("redir_addr", Icache_addr, 32'h100);
    Icache_valid = 1;
    Icache_data = 32'hDEAD_BEEF;
    tick;
    Icache_valid = 0;
    chk("drop_empty", 32'(Ifq_empty), 1);
    chk("drop_inst", Ifq_inst, 0);
    chk("drop_req", 32'(Icache_req), 1);
    chk("drop_addr", Icache_addr, 32'h100);
    fetch(32'hB000_0000);
    chk("one_inst", Ifq_inst, 32'hB000_0000);
    chk("one_pc", Ifq_pc, 32'h100);
    tick;
    Icache_valid = 1;
    Icache_data = 32'hB000_0001;
    Dispatch_ren = 1;
    tick;
    Icache_valid = 0;
    Dispatch_ren = 0;
    Icache_ready = 0;
    chk("pp_empty", 32'(Ifq_empty), 0);
    chk("pp_inst", Ifq_inst, 32'hB000_0001);
    chk("pp_pc", Ifq_pc, 32'h104);
    Dispatch_ren = 1;
    tick;
    chk("pp_occ1_empty", 32'(Ifq_empty), 1);
    tick;
    Dispatch_ren = 0;
    chk("ren_empty_ignored", 32'(Ifq_empty), 1);
    chk("ren_empty_req", 32'(Icache_req), 1);
    Icache_valid = 1;
    Icache_data = 32'hC000_0000;
    tick;
    Icache_valid = 0;
    chk("idle_valid_empty", 32'(Ifq_empty), 1);
    chk("idle_valid_addr", Icache_addr, 32'h108);
    Icache_ready = 1;
    fetch(32'hC000_0001);
    chk("pre_rst_inst", Ifq_inst, 32'hC000_0001);
    chk("pre_rst_pc", Ifq_pc, 32'h108);
    tick;
    reset = 0;
    #1;
    chk("arst_req", 32'(Icache_req), 0);
    chk("arst_empty", 32'(Ifq_empty), 1);
    chk("arst_inst", Ifq_inst, 0);
    chk("arst_pc", Ifq_pc, 0);
    chk("arst_addr", Icache_addr, 0);
    tick;
    reset = 1;
    Icache_ready = 0;
    Icache_valid = 1;
    Icache_data = 32'hEEEE_EEEE;
    tick;
    Icache_valid = 0;
    chk("stale_empty", 32'(Ifq_empty), 1);
    chk("stale_req", 32'(Icache_req), 1);
    chk("stale_addr", Icache_addr, 0);
    Icache_ready = 1;
    fetch(32'hD000_0000);
    chk("post_rst_inst", Ifq_inst, 32'hD000_0000);
    chk("post_rst_pc", Ifq_pc, 0);
    Jmp_branch_valid = 1;
    Jmp_branch_address = 32'h203;
    Dispatch_ren = 1;
    #1;
    chk("jmp_req", 32'(Icache_req), 0);
    tick;
    Jmp_branch_valid = 0;
    Dispatch_ren = 0;
    chk("jmp_empty", 32'(Ifq_empty), 1);
    chk("jmp_addr_align", Icache_addr, 32'h200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
 - clock  in  1  single clock, rising edge.
 - reset  in  1  asynchronous, active-low reset.
 - Icache_req  out  1  fetch request valid.
 - Icache_addr  out  32  fetch address (word aligned).
 - Icache_ready  in  1  cache accepts the request this cycle.
 - Icache_valid  in  1  returned instruction valid.
 - Icache_data  in  32  returned instruction.
 - Ifq_inst  out  32  head instruction.
 - Ifq_pc  out  32  head PC.
 - Ifq_empty  out  1  queue holds no entry.
 - Dispatch_ren  in  1  dispatch pops the head.
 - Jmp_branch_valid  in  1  redirect request.
 - Jmp_branch_address  in  32  redirect target.

Function
REQ-004 The block SHALL have FSM states IDLE, WAIT and DISCARD, with at most one cache request outstanding.
REQ-005 In IDLE, Icache_req SHALL be 1 when occupancy plus one is at most DEPTH and Jmp_branch_valid is 0. Request accepted when Icache_req and Icache_ready are both 1; the FSM then goes to WAIT.
REQ-006 In WAIT, when Icache_valid is 1, the block SHALL write {Icache_data, fetch PC} at the tail, set fetch PC to fetch PC + 4, and return to IDLE.
REQ-007 Icache_valid SHALL be ignored in IDLE.
REQ-008 Latency: a response SHALL be visible on Ifq_inst/Ifq_pc, with Ifq_empty = 0, on the cycle after Icache_valid.
REQ-009 Dispatch_ren while Ifq_empty = 1 SHALL be ignored.
REQ-010 A pop and a push in the same cycle SHALL leave occupancy unchanged.
REQ-011 Read and write pointers SHALL wrap modulo DEPTH. Occupancy SHALL be held in a counter of log2(DEPTH)+1 bits.
REQ-012 Jmp_branch_valid = 1 SHALL clear the queue, load the fetch PC with Jmp_branch_address, and ignore same-cycle Dispatch_ren and Icache_valid.
REQ-013 Jmp_branch_valid SHALL move the FSM to IDLE from IDLE or DISCARD, and to DISCARD from WAIT.
REQ-014 Jmp_branch_valid takes priority over all other events in that cycle.
REQ-015 In DISCARD, Icache_req SHALL be 0; the next Icache_valid SHALL be dropped and the FSM SHALL go to IDLE.
REQ-016 Icache_addr SHALL equal the fetch PC at all times, with bits [1:0] forced to 0.

Reset
REQ-017 While reset is 0, the block SHALL set: FSM = IDLE, fetch PC = RESET_PC, pointers and occupancy = 0, Ifq_empty = 1, Icache_req = 0, Ifq_inst = 0, Ifq_pc = 0.
REQ-018 A reset asserted in WAIT SHALL drop any in-flight response arriving after reset release. The block SHALL treat the first cycle after release as DISCARD only if Icache_valid arrives before any new request is accepted.

Configuration
REQ-019 With IFQ_PERF_EN defined, the block SHALL add outputs Ifq_stall_cnt[31:0] and Ifq_flush_cnt[15:0], both reset to 0 and saturating.
 - Ifq_stall_cnt increments each cycle the FSM is in IDLE and the queue is too full to request.
 - Ifq_flush_cnt increments on each Jmp_branch_valid.
REQ-020 Without IFQ_PERF_EN, neither the ports nor the counters SHALL exist; behaviour is otherwise identical.

Structure
REQ-021 A shared package SHALL hold the FSM state enum (IDLE, WAIT, DISCARD), the 32-bit instruction/PC entry typedef, and the PC increment constant 4.
REQ-022 Storage SHALL be one sub-module, ifq_fifo: a DEPTH-entry synchronous-write, asynchronous-read FIFO with flush input.

Verification
REQ-023 Reset release, Icache_ready = 1, responses one cycle after request -> Icache_addr sequence 0x0, 0x4, 0x8, 0xC; Ifq_pc head = 0x0.
REQ-024 No Dispatch_ren and DEPTH = 4 -> four entries stored; Icache_req stays 0 and Ifq_empty stays 0.
REQ-025 Queue full, one Dispatch_ren -> Icache_req reasserts the next cycle at address 0x10.
REQ-026 Redirect to 0x100 while in WAIT, then Icache_valid with 0xDEAD_BEEF -> response dropped, Ifq_empty = 1, next Icache_addr = 0x100.
REQ-027 Simultaneous Dispatch_ren and Icache_valid with one entry held -> occupancy remains 1, and head becomes the new instruction.
REQ-028 Reset asserted in WAIT -> all outputs at reset values immediately, without waiting for a clock edge.
